// File: rtl/spi_memory_master_if.sv
// Host-side bus bundle for spi_memory_master: request/response handshake plus the SPI pins.
// The abort input exists only when SPI_MASTER_ABORT_EN is defined.
interface spi_memory_master_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] length;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;
`ifdef SPI_MASTER_ABORT_EN
    logic       abort;
`endif

    modport master (
        input  start, rw, addr, length, tx_data, miso,
`ifdef SPI_MASTER_ABORT_EN
        input  abort,
`endif
        output tx_req, rx_data, rx_valid, busy, done, sck, cs, mosi
    );

    modport slave (
        output start, rw, addr, length, tx_data, miso,
`ifdef SPI_MASTER_ABORT_EN
        output abort,
`endif
        input  tx_req, rx_data, rx_valid, busy, done, sck, cs, mosi
    );
endinterface

// File: rtl/spi_memory_master.sv
// Mode-0 SPI initiator for the memory-slave protocol: command, address, then `length` data bytes, MSB first.
// SPI_MASTER_ABORT_EN adds bus.abort, which ends a transfer after the current bit's high phase.
module spi_memory_master #(
    parameter int CLK_DIV = 5
) (
    input  logic                main_clock,
    input  logic                rst_n,
    spi_memory_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state, state_nxt;
    logic [7:0] div_cnt;
    logic       phase;
    logic [2:0] bit_cnt;
    logic [8:0] byte_idx;
    logic       rw_q;
    logic [7:0] addr_q;
    logic [7:0] len_q;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic       miso_s1, miso_s2;
    logic       sck_q, cs_q, mosi_q, busy_q, done_q, rx_valid_q;
    logic [7:0] rx_data_q;

    logic       tick, bit_end, byte_end, last_byte, abort_req, stop, load_next, tx_load;
    logic [7:0] next_byte, cmd_byte;

`ifdef SPI_MASTER_ABORT_EN
    logic abort_pend;

    // Remember an abort seen anywhere in the bit so it takes effect at the bit boundary.
    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            abort_pend <= 1'b0;
        end else if (state == SHIFT && bus.abort) begin
            abort_pend <= 1'b1;
        end else if (state == IDLE) begin
            abort_pend <= 1'b0;
        end
    end

    assign abort_req = abort_pend | bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        tick      = (div_cnt == DIV_LAST);
        bit_end   = (state == SHIFT) && phase && tick;
        byte_end  = bit_end && (bit_cnt == 3'd7);
        last_byte = (byte_idx == ({1'b0, len_q} + 9'd1));
        stop      = (bit_end && abort_req) || (byte_end && last_byte);
        load_next = byte_end && !last_byte && !abort_req;
        tx_load   = load_next && !rw_q && (byte_idx != 9'd0);
        cmd_byte  = bus.rw ? 8'h03 : 8'h02;

        next_byte = 8'h00;
        if (byte_idx == 9'd0) begin
            next_byte = addr_q;
        end else if (!rw_q) begin
            next_byte = bus.tx_data;
        end

        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (stop)      state_nxt = HOLD;
            HOLD:    if (tick)      state_nxt = GAP;
            GAP:     if (tick)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= 8'd0;
            phase      <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_idx   <= 9'd0;
            rw_q       <= 1'b0;
            addr_q     <= 8'h00;
            len_q      <= 8'h00;
            tx_sh      <= 8'h00;
            rx_sh      <= 8'h00;
            miso_s1    <= 1'b0;
            miso_s2    <= 1'b0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            miso_s1    <= bus.miso;
            miso_s2    <= miso_s1;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            div_cnt    <= (state == IDLE || tick) ? 8'd0 : div_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rw_q     <= bus.rw;
                        addr_q   <= bus.addr;
                        len_q    <= bus.length;
                        mosi_q   <= cmd_byte[7];
                        tx_sh    <= {cmd_byte[6:0], 1'b0};
                        cs_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        phase    <= 1'b0;
                        bit_cnt  <= 3'd0;
                        byte_idx <= 9'd0;
                    end
                end
                SHIFT: begin
                    if (tick && !phase) begin
                        phase <= 1'b1;
                        sck_q <= 1'b1;
                        rx_sh <= {rx_sh[6:0], miso_s2};
                        if (bit_cnt == 3'd7 && rw_q && byte_idx >= 9'd2) begin
                            rx_data_q  <= {rx_sh[6:0], miso_s2};
                            rx_valid_q <= 1'b1;
                        end
                    end
                    if (bit_end) begin
                        phase <= 1'b0;
                        sck_q <= 1'b0;
                        if (stop) begin
                            mosi_q <= 1'b0;
                        end else if (bit_cnt == 3'd7) begin
                            bit_cnt  <= 3'd0;
                            byte_idx <= byte_idx + 9'd1;
                            mosi_q   <= next_byte[7];
                            tx_sh    <= {next_byte[6:0], 1'b0};
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            mosi_q  <= tx_sh[7];
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_q   <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                GAP: begin
                    if (tick) busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.sck      = sck_q;
    assign bus.cs       = cs_q;
    assign bus.mosi     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    // tx_req marks the cycle whose closing edge captures tx_data into the shifter.
    assign bus.tx_req   = tx_load;
endmodule

// File: tb/tb_spi_memory_master.sv
// Directed bench for spi_memory_master at CLK_DIV=5: vector table plus busy-start, reset and abort sequences.
module tb_spi_memory_master;
    localparam int DIV = 5;

    logic main_clock;
    logic rst_n;
    spi_memory_master_if bus();

    spi_memory_master #(.CLK_DIV(DIV)) dut (
        .main_clock(main_clock),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial begin
        main_clock = 1'b0;
        forever #5 main_clock = ~main_clock;
    end

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [7:0]  len;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
        logic [7:0]  rsp;
        int          rises;
        logic [31:0] mosi;
        int          txreq;
        int          cslow;
        int          rxv;
        logic [7:0]  rxd;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder bit for the bit index that the next sck rise will sample.
    function automatic logic resp_bit(input logic [7:0] b, input int k);
        if (k < 16) return 1'b0;
        return b[7 - ((k - 16) % 8)];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " cs"},       32'(bus.cs),       32'd1);
        chk({tag, " sck"},      32'(bus.sck),      32'd0);
        chk({tag, " mosi"},     32'(bus.mosi),     32'd0);
        chk({tag, " busy"},     32'(bus.busy),     32'd0);
        chk({tag, " done"},     32'(bus.done),     32'd0);
        chk({tag, " tx_req"},   32'(bus.tx_req),   32'd0);
        chk({tag, " rx_valid"}, 32'(bus.rx_valid), 32'd0);
        chk({tag, " rx_data"},  32'(bus.rx_data),  32'h00);
    endtask

    task automatic run_xfer(input vec_t v, input string tag, input int inject_at, input int rst_at);
        int          rises, txn, tx_first, tx_last, cslow, dn, done_n, busy_low_n, rxv, first_rise;
        logic [31:0] mosi_bits;
        logic [7:0]  rxd;
        logic        prev_sck;
        logic        finished;
        rises = 0; txn = 0; tx_first = 0; tx_last = 0; cslow = 0; dn = 0;
        done_n = 0; busy_low_n = 0; rxv = 0; first_rise = 0;
        mosi_bits = 32'h0; rxd = 8'h00; prev_sck = 1'b0; finished = 1'b0;

        @(negedge main_clock);
        bus.rw = v.rw; bus.addr = v.addr; bus.length = v.len;
        bus.tx_data = v.tx0; bus.miso = 1'b0; bus.start = 1'b1;

        for (int n = 1; n < 20000 && !finished; n++) begin
            @(negedge main_clock);
            bus.start = (n == inject_at);
            if (n == inject_at) begin
                bus.addr = 8'hEE; bus.rw = ~v.rw; bus.length = 8'd9;
            end
            if (n == 1) begin
                chk({tag, " cs fall"},  32'(bus.cs),   32'd0);
                chk({tag, " cmd msb"},  32'(bus.mosi), 32'd0);
                chk({tag, " busy set"}, 32'(bus.busy), 32'd1);
            end
            bus.tx_data = (txn == 0) ? v.tx0 : v.tx1;
            if (bus.tx_req) begin
                if (txn == 0) tx_first = n;
                tx_last = n;
                txn++;
            end
            if (bus.sck && !prev_sck) begin
                mosi_bits = {mosi_bits[30:0], bus.mosi};
                if (rises == 0) first_rise = n;
                rises++;
                bus.miso = resp_bit(v.rsp, rises);
                if (rises == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle({tag, " async"});
                    @(negedge main_clock);
                    rst_n = 1'b1;
                    bus.miso = 1'b0;
                    return;
                end
            end
            prev_sck = bus.sck;
            if (!bus.cs) cslow++;
            if (bus.done) begin dn++; done_n = n; end
            if (bus.rx_valid) begin rxv++; rxd = bus.rx_data; end
            if (dn > 0 && !bus.busy) begin busy_low_n = n; finished = 1'b1; end
        end

        chk({tag, " completed"},  32'(finished), 32'd1);
        chk({tag, " rises"},      rises, v.rises);
        chk({tag, " mosi bits"},  mosi_bits, v.mosi);
        chk({tag, " tx_req cnt"}, txn, v.txreq);
        chk({tag, " cs low"},     cslow, v.cslow);
        chk({tag, " done cnt"},   dn, 1);
        chk({tag, " rx_valid"},   rxv, v.rxv);
        if (v.rxv > 0) chk({tag, " rx_data"}, 32'(rxd), 32'(v.rxd));
        chk({tag, " first rise"}, first_rise, 1 + DIV);
        chk({tag, " busy tail"},  busy_low_n - done_n, DIV);
        if (v.txreq == 2) chk({tag, " tx_req gap"}, tx_last - tx_first, 16 * DIV);
    endtask

    vec_t vecs[5];
    vec_t v_busy;
`ifdef SPI_MASTER_ABORT_EN
    vec_t v_abort;
`endif

    initial begin
        vecs[0] = '{1'b0, 8'hAB, 8'd2, 8'hCD, 8'h53, 8'h00, 32, 32'h02ABCD53, 2, 325, 0, 8'h00};
        vecs[1] = '{1'b1, 8'h10, 8'd1, 8'h00, 8'h00, 8'hAB, 24, 32'h00031000, 0, 245, 1, 8'hAB};
        vecs[2] = '{1'b0, 8'h7F, 8'd0, 8'h00, 8'h00, 8'h00, 16, 32'h0000027F, 0, 165, 0, 8'h00};
        vecs[3] = '{1'b1, 8'h5A, 8'd2, 8'h00, 8'h00, 8'h3C, 32, 32'h035A0000, 0, 325, 2, 8'h3C};
        vecs[4] = '{1'b0, 8'h55, 8'd1, 8'hA5, 8'h00, 8'h00, 24, 32'h000255A5, 1, 245, 0, 8'h00};
        v_busy  = '{1'b0, 8'h11, 8'd0, 8'h00, 8'h00, 8'h00, 16, 32'h00000211, 0, 165, 0, 8'h00};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 8'h00; bus.length = 8'h00;
        bus.tx_data = 8'h00; bus.miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
        bus.abort = 1'b0;
`endif
        #12;
        chk_idle("reset");
        @(negedge main_clock);
        rst_n = 1'b1;
        repeat (3) @(negedge main_clock);
        chk_idle("post reset idle");

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i), -1, -1);
        end

        run_xfer(v_busy, "start while busy", 30, -1);

        run_xfer(vecs[0], "reset mid addr", -1, 10);
        run_xfer(vecs[0], "after reset", -1, -1);

`ifdef SPI_MASTER_ABORT_EN
        v_abort = '{1'b1, 8'h20, 8'd4, 8'h00, 8'h00, 8'h96, 26, 32'h000C8000, 0, 265, 1, 8'h96};
        fork
            run_xfer(v_abort, "abort", -1, -1);
            begin : abort_drv
                int  r;
                logic p;
                r = 0;
                p = 1'b0;
                for (int k = 0; k < 5000 && r < 26; k++) begin
                    @(negedge main_clock);
                    if (bus.sck && !p) r++;
                    p = bus.sck;
                end
                bus.abort = 1'b1;
                @(negedge main_clock);
                bus.abort = 1'b0;
            end
        join
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_memory_master.md
# spi_memory_master

SPI mode-0 initiator for the single-bit memory-slave protocol: one command byte (0x02 write, 0x03 read), one address byte, then N data bytes, all MSB first. It generates sck/cs from main_clock by division and shifts data out on mosi or in from miso. It sits between on-chip control logic and an external or on-board memory-slave port, and is the host-side counterpart of the memory slave.

## Interface
- CLK_DIV, 5: main_clock cycles per sck half-period; legal range 2..255.
- main_clock  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- rw  in  1  1 = read (cmd 0x03), 0 = write (cmd 0x02); sampled with start.
- addr  in  8  address byte; sampled with start.
- length  in  8  data bytes, 0..255; 0 means command and address only; sampled with start.
- tx_data  in  8  next write byte; sampled in the tx_req cycle.
- tx_req  out  1  one-cycle pulse when tx_data is loaded into the shifter.
- rx_data  out  8  last received byte; valid while rx_valid=1, held afterwards.
- rx_valid  out  1  one-cycle pulse per received data byte.
- busy  out  1  high from the start-accept cycle through the end of GAP.
- done  out  1  one-cycle pulse when cs returns high.
- sck  out  1  SPI clock, idle low.
- cs  out  1  chip select, active low, idle high.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; registered before use.

## Operation
- Reset values: sck=0, cs=1, mosi=0, busy=0, done=0, tx_req=0, rx_valid=0, rx_data=0x00. Reset takes effect immediately at any time, including mid-transfer.
- States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: on start, latch rw/addr/length, load the command byte, drive cs=0, and set busy.
- SHIFT: each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - mosi updates in the first cycle of the low phase.
  - miso (synchronised) is sampled in the cycle sck rises.
  - Byte order: command, address, then `length` data bytes.
- Write data phase:
  - At each data-byte load, tx_data is latched and tx_req pulses in that same cycle.
  - The first load occurs at the address/data boundary.
- Read data phase:
  - mosi=0.
  - After the 8th sample of each byte, rx_data is updated and rx_valid pulses on the next cycle.
- After the last bit's high phase, go to HOLD: sck=0, cs=0 for CLK_DIV cycles.
- HOLD -> GAP: cs=1 and done pulses. GAP holds cs=1 for CLK_DIV cycles, then returns to IDLE with busy=0.
- start while busy=1 is ignored, with no queuing.
- Byte counter is 9 bits wide so that length=255 (257 bytes on the bus) does not wrap.

## Timing
- Accept cycle T: cs falls at T+1 and mosi=cmd[7] at T+1.
- First sck rise at T+1+CLK_DIV.
- Total cs-low duration: (16+8*length)*2*CLK_DIV + CLK_DIV cycles.
- done pulses in the first cs-high cycle. busy falls CLK_DIV cycles later.
- Consecutive tx_req pulses are 16*CLK_DIV cycles apart. tx_data must be stable in each tx_req cycle.
- miso path: 2-flop synchroniser. The sample taken at a rising edge uses the value present 2 cycles earlier. The slave must hold miso for at least CLK_DIV-2 cycles around the rise.

## Configuration
- SPI_MASTER_ABORT_EN:
  - When defined, adds input port `abort` (1 bit).
  - abort=1 in SHIFT lets the current bit finish its high phase, then forces HOLD.
  - No rx_valid is emitted for a partial byte, no further tx_req is issued, and done still pulses.
  - abort is ignored outside SHIFT.
  - When undefined, the port is absent and every transfer runs to completion.

## Test plan
- CLK_DIV=5, write, addr=0xAB, length=2, tx_data 0xCD then 0x53:
  - mosi sampled at sck rises = 00000010 10101011 11001101 01010011.
  - 32 rises, 2 tx_req pulses 80 cycles apart.
  - cs low for 325 cycles, done once.
- Read, addr=0x10, length=1, responder drives 0xAB during the data byte:
  - mosi carries 0x03 0x10 0x00.
  - rx_valid pulses once with rx_data=0xAB.
- length=0 write, addr=0x7F: exactly 16 sck rises, no tx_req, done once, busy low CLK_DIV cycles after done.
- start with different addr asserted while busy: ignored, no change to the bus sequence, single done.
- rst_n pulsed low during the address byte: same cycle gives cs=1, sck=0, mosi=0, busy=0. Next start then runs a clean full transfer.
- With SPI_MASTER_ABORT_EN, read length=4, abort during 2nd data byte:
  - Exactly 1 rx_valid.
  - cs rises CLK_DIV cycles after that bit's high phase ends.
  - done once.
